// File: rtl/debounce_scheduler.sv
// Shared-timer button debouncer: synchronised rising edges queue requests that are granted
// round-robin to a single window timer; a clean one-cycle pulse follows if the button is still held.
module debounce_scheduler #(
   parameter int N_BTN       = 4,
   parameter int ID_W        = 2,
   parameter int CLK_KHZ     = 50000,
   parameter int DURACION_MS = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] pulso_real,
   output logic [N_BTN-1:0] pulso_ideal,
   output logic             busy,
   output logic [ID_W-1:0]  active_id
);

   localparam logic [31:0]      LIMIT      = 32'(CLK_KHZ * DURACION_MS);
   localparam logic [31:0]      LAST_COUNT = LIMIT - 32'd1;
   localparam logic [ID_W-1:0]  RR_RESET   = ID_W'(N_BTN - 1);
   localparam logic [N_BTN-1:0] ONE_BTN    = {{(N_BTN-1){1'b0}}, 1'b1};
   localparam logic [N_BTN-1:0] NO_BTN     = {N_BTN{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [N_BTN-1:0] s1_r;
   logic [N_BTN-1:0] s2_r;
   logic [N_BTN-1:0] s2_d_r;
   logic [N_BTN-1:0] pending_r;
   logic [N_BTN-1:0] pending_s;
   logic [N_BTN-1:0] pulse_r;
   logic [N_BTN-1:0] pulse_s;
   logic [N_BTN-1:0] rise_s;
   logic [N_BTN-1:0] own_mask_s;
   logic [N_BTN-1:0] clear_mask_s;
   logic [31:0]      counter_r;
   logic [31:0]      counter_s;
   logic [ID_W-1:0]  active_id_r;
   logic [ID_W-1:0]  active_id_s;
   logic [ID_W-1:0]  rr_ptr_r;
   logic [ID_W-1:0]  rr_ptr_s;
   logic [ID_W-1:0]  grant_idx_s;
   logic [ID_W-1:0]  cand_s;
   logic             grant_found_s;
   logic             hit_s;
   logic             busy_r;
   logic             busy_s;

   // Two-flop synchroniser plus a delayed copy for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r   <= NO_BTN;
         s2_r   <= NO_BTN;
         s2_d_r <= NO_BTN;
      end else begin
         s1_r   <= pulso_real;
         s2_r   <= s1_r;
         s2_d_r <= s2_r;
      end
   end

   // Round-robin search: first pending bit after rr_ptr, wrapping modulo N_BTN.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = {ID_W{1'b0}};
      cand_s        = {ID_W{1'b0}};
      hit_s         = 1'b0;
      for (int k = 1; k <= N_BTN; k++) begin
         cand_s        = ID_W'((int'(rr_ptr_r) + k) % N_BTN);
         hit_s         = pending_r[cand_s] & ~grant_found_s;
         grant_idx_s   = hit_s ? cand_s : grant_idx_s;
         grant_found_s = grant_found_s | hit_s;
      end
   end

   // Next-state, timer, grant bookkeeping and pulse generation.
   always_comb begin
      state_s      = state_r;
      counter_s    = counter_r;
      active_id_s  = active_id_r;
      rr_ptr_s     = rr_ptr_r;
      pulse_s      = NO_BTN;
      clear_mask_s = NO_BTN;
      case (state_r)
         ST_IDLE: begin
            if (grant_found_s) begin
               active_id_s  = grant_idx_s;
               rr_ptr_s     = grant_idx_s;
               clear_mask_s = ONE_BTN << grant_idx_s;
               counter_s    = 32'd0;
               state_s      = ST_COUNT;
            end else begin
               state_s      = ST_IDLE;
            end
         end
         ST_COUNT: begin
            // LAST_COUNT is terminal, so the counter can never wrap.
            if (counter_r == LAST_COUNT) begin
               state_s   = ST_CHECK;
            end else begin
               counter_s = counter_r + 32'd1;
            end
         end
         ST_CHECK: begin
            pulse_s   = s2_r[active_id_r] ? (ONE_BTN << active_id_r) : NO_BTN;
            counter_s = 32'd0;
            state_s   = ST_IDLE;
         end
         default: begin
            counter_s = 32'd0;
            state_s   = ST_IDLE;
         end
      endcase

      busy_s     = (state_s == ST_COUNT) || (state_s == ST_CHECK);
      rise_s     = s2_r & ~s2_d_r;
      // Edges from the button that owns the timer are bounce, not new requests.
      own_mask_s = busy_r ? (ONE_BTN << active_id_r) : NO_BTN;
      pending_s  = (pending_r | (rise_s & ~own_mask_s)) & ~clear_mask_s;
   end

   // Scheduler state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         counter_r   <= 32'd0;
         active_id_r <= {ID_W{1'b0}};
         rr_ptr_r    <= RR_RESET;
         pending_r   <= NO_BTN;
         pulse_r     <= NO_BTN;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         counter_r   <= counter_s;
         active_id_r <= active_id_s;
         rr_ptr_r    <= rr_ptr_s;
         pending_r   <= pending_s;
         pulse_r     <= pulse_s;
         busy_r      <= busy_s;
      end
   end

   assign pulso_ideal = pulse_r;
   assign busy        = busy_r;
   assign active_id   = active_id_r;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios plus random button traffic, compared every
// cycle with a time-based reference model (grant instants and window deadlines).
module tb_debounce_scheduler;

   localparam int N_BTN       = 4;
   localparam int ID_W        = 2;
   localparam int CLK_KHZ     = 10;
   localparam int DURACION_MS = 2;
   localparam int LIMIT       = CLK_KHZ * DURACION_MS;
   localparam int MAXC        = 16384;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] pulso_real;
   logic [N_BTN-1:0] pulso_ideal;
   logic             busy;
   logic [ID_W-1:0]  active_id;

   debounce_scheduler #(
      .N_BTN      (N_BTN),
      .ID_W       (ID_W),
      .CLK_KHZ    (CLK_KHZ),
      .DURACION_MS(DURACION_MS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pulso_real (pulso_real),
      .pulso_ideal(pulso_ideal),
      .busy       (busy),
      .active_id  (active_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 8;

   // hist[k] is the button vector sampled at edge k; the synchronised value after edge k is hist[k-1]
   logic [N_BTN-1:0] hist [MAXC];

   logic [N_BTN-1:0] m_pend;
   logic [ID_W-1:0]  m_owner;
   logic [ID_W-1:0]  m_rr;
   bit               m_owned;
   int               m_busy_until;
   logic [N_BTN-1:0] exp_pulse;
   logic             exp_busy;
   logic [ID_W-1:0]  exp_id;

   int pulse_cnt  [N_BTN];
   int last_pulse [N_BTN];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [N_BTN-1:0] sync_at(input int k);
      return hist[k-1];
   endfunction

   task automatic model_step(input logic rst_v);
      logic [N_BTN-1:0] rise;
      logic [N_BTN-1:0] mask;
      logic [N_BTN-1:0] newp;
      logic [N_BTN-1:0] held;
      bit               prev_busy;
      int               g;
      int               idx;
      if (rst_v) begin
         hist[cyc]    = '0;
         hist[cyc-1]  = '0;
         m_pend       = '0;
         m_owner      = '0;
         m_rr         = ID_W'(N_BTN - 1);
         m_owned      = 1'b0;
         m_busy_until = -10;
         exp_pulse    = '0;
         exp_busy     = 1'b0;
         exp_id       = '0;
      end else begin
         prev_busy = m_owned && (cyc - 1 <= m_busy_until);
         exp_pulse = '0;
         if (m_owned && cyc == m_busy_until + 1) begin
            held = sync_at(m_busy_until);
            if (held[m_owner]) exp_pulse = 4'b0001 << m_owner;
         end
         rise = sync_at(cyc - 1) & ~sync_at(cyc - 2);
         mask = prev_busy ? (4'b0001 << m_owner) : 4'b0000;
         newp = m_pend | (rise & ~mask);
         if (!prev_busy && m_pend != '0) begin
            g = -1;
            for (int k = 1; k <= N_BTN; k++) begin
               idx = (int'(m_rr) + k) % N_BTN;
               if (g < 0 && m_pend[idx[1:0]]) g = idx;
            end
            m_rr         = ID_W'(g);
            m_owner      = ID_W'(g);
            m_owned      = 1'b1;
            m_busy_until = cyc + LIMIT;
            newp[g[1:0]] = 1'b0;
         end
         m_pend   = newp;
         exp_busy = m_owned && (cyc <= m_busy_until);
         exp_id   = m_owner;
      end
   endtask

   task automatic tick(input logic [N_BTN-1:0] btn, input logic rst_v);
      pulso_real = btn;
      rst        = rst_v;
      @(posedge clk);
      cyc++;
      hist[cyc] = btn;
      model_step(rst_v);
      #1;
      check_val("pulso_ideal", 32'(pulso_ideal), 32'(exp_pulse));
      check_val("busy", 32'(busy), 32'(exp_busy));
      check_val("active_id", 32'(active_id), 32'(exp_id));
      for (int i = 0; i < N_BTN; i++) begin
         if (pulso_ideal[i] === 1'b1) begin
            pulse_cnt[i]++;
            last_pulse[i] = cyc;
         end
      end
   endtask

   initial begin
      int t0;
      int c0;
      int rate;
      logic [N_BTN-1:0] btn;
      for (int i = 0; i < MAXC; i++) hist[i] = '0;
      for (int i = 0; i < N_BTN; i++) begin
         pulse_cnt[i]  = 0;
         last_pulse[i] = -1;
      end

      tick(4'b0000, 1'b1);
      tick(4'b0000, 1'b1);
      check_val("reset_pulso", 32'(pulso_ideal), 32'd0);
      check_val("reset_busy", 32'(busy), 32'd0);
      check_val("reset_id", 32'(active_id), 32'd0);
      repeat (5) tick(4'b0000, 1'b0);

      // single clean press
      t0 = cyc + 1;
      c0 = pulse_cnt[0];
      repeat (40) tick(4'b0001, 1'b0);
      check_val("s1_pulse_cycle", 32'(last_pulse[0]), 32'(t0 + LIMIT + 4));
      check_val("s1_pulse_count", 32'(pulse_cnt[0] - c0), 32'd1);
      repeat (10) tick(4'b0000, 1'b0);

      // bouncing press
      c0 = pulse_cnt[1];
      for (int k = 0; k < 15; k++) tick(((k / 3) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
      repeat (40) tick(4'b0010, 1'b0);
      check_val("s2_pulse_count", 32'(pulse_cnt[1] - c0), 32'd1);
      repeat (10) tick(4'b0000, 1'b0);

      // short glitch
      c0 = pulse_cnt[2];
      repeat (4) tick(4'b0100, 1'b0);
      repeat (35) tick(4'b0000, 1'b0);
      check_val("s3_pulse_count", 32'(pulse_cnt[2] - c0), 32'd0);
      check_val("s3_busy", 32'(busy), 32'd0);
      check_val("s3_active_id", 32'(active_id), 32'd2);

      // simultaneous requests from a fresh reset
      tick(4'b0000, 1'b1);
      repeat (3) tick(4'b0000, 1'b0);
      t0 = cyc + 1;
      repeat (100) tick(4'b1111, 1'b0);
      check_val("s4_first", 32'(last_pulse[0]), 32'(t0 + LIMIT + 4));
      check_val("s4_gap01", 32'(last_pulse[1] - last_pulse[0]), 32'(LIMIT + 2));
      check_val("s4_gap12", 32'(last_pulse[2] - last_pulse[1]), 32'(LIMIT + 2));
      check_val("s4_gap23", 32'(last_pulse[3] - last_pulse[2]), 32'(LIMIT + 2));
      repeat (10) tick(4'b0000, 1'b0);

      // fairness after a grant to 3
      t0 = cyc + 1;
      repeat (60) tick(4'b1001, 1'b0);
      check_val("s5_btn0", 32'(last_pulse[0]), 32'(t0 + LIMIT + 4));
      check_val("s5_btn3", 32'(last_pulse[3]), 32'(t0 + 2 * LIMIT + 6));
      repeat (10) tick(4'b0000, 1'b0);

      // reset in the middle of a window
      c0 = pulse_cnt[0];
      repeat (14) tick(4'b0001, 1'b0);
      tick(4'b0000, 1'b1);
      check_val("s6_rst_busy", 32'(busy), 32'd0);
      check_val("s6_rst_id", 32'(active_id), 32'd0);
      repeat (30) tick(4'b0000, 1'b0);
      check_val("s6_no_pulse", 32'(pulse_cnt[0] - c0), 32'd0);
      t0 = cyc + 1;
      repeat (40) tick(4'b0001, 1'b0);
      check_val("s6_repress", 32'(last_pulse[0]), 32'(t0 + LIMIT + 4));
      repeat (10) tick(4'b0000, 1'b0);

      // random traffic: bouncy first half, slow presses second half, rare resets
      btn = '0;
      for (int n = 0; n < 4000; n++) begin
         rate = (n < 2000) ? 4 : 40;
         for (int b = 0; b < N_BTN; b++) begin
            if ($urandom_range(rate - 1) == 0) btn[b] = ~btn[b];
         end
         tick(btn, ($urandom_range(799) == 0) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
